// File: rtl/rv_core_pkg.sv
// Shared definitions for the single-cycle RISC-V core: sequencer states and opcode encodings.
package rv_core_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALT,
    FAULT
  } seq_state_t;

  localparam logic [6:0] OP_NOP    = 7'b0000000;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

endpackage

// File: rtl/pc_target_calc.sv
// Next-PC arithmetic: sequential or redirected target plus legality flags against the ROM.
module pc_target_calc #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_INST = 19
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] offset,
  input  logic             redirect,
  output logic [WIDTH-1:0] target,
  output logic             misaligned,
  output logic             out_of_range
);

  always_comb begin
    target       = pc + (redirect ? offset : WIDTH'(4));
    misaligned   = |target[1:0];
    out_of_range = (target >> 2) >= WIDTH'(NUM_INST);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter owner: waits out instruction-memory latency, issues with a valid/done
// handshake, and ends on NO-OP, falling off the ROM, or an illegal redirect.
module fetch_sequencer
  import rv_core_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_INST  = 19,
  parameter int unsigned FETCH_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic [WIDTH-1:0] offset,
  input  logic             exec_done,
  output logic [WIDTH-1:0] pc,
  output logic             inst_valid,
  output logic             halted,
  output logic             fault,
  output logic [WIDTH-1:0] retired
);

  localparam logic [WIDTH-1:0] WAIT_INIT = WIDTH'(FETCH_LAT - 1);

  seq_state_t       state, state_nxt;
  logic [WIDTH-1:0] wait_cnt;
  logic [WIDTH-1:0] target;
  logic             misaligned, out_of_range;
  logic             redirect, issue_fire;

  assign redirect   = branch_taken | jump;
  assign issue_fire = (state == ISSUE) && (opcode != OP_NOP) && exec_done;

  pc_target_calc #(
    .WIDTH    (WIDTH),
    .NUM_INST (NUM_INST)
  ) u_target (
    .pc           (pc),
    .offset       (offset),
    .redirect     (redirect),
    .target       (target),
    .misaligned   (misaligned),
    .out_of_range (out_of_range)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: if (!stall && wait_cnt == '0) state_nxt = ISSUE;
      ISSUE: begin
        if (opcode == OP_NOP) begin
          state_nxt = HALT;
        end else if (exec_done) begin
          // A sequential target is always aligned, so only range matters there.
          if (redirect && (misaligned || out_of_range)) state_nxt = FAULT;
          else if (out_of_range)                        state_nxt = HALT;
          else                                          state_nxt = FETCH;
        end
      end
      HALT:  state_nxt = HALT;
      FAULT: state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          pc <= '0;
          if (start) wait_cnt <= WAIT_INIT;
        end
        FETCH: if (!stall && wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
        ISSUE: begin
          if (issue_fire) begin
            retired <= retired + 1'b1;
            if (state_nxt == FETCH) begin
              pc       <= target;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    inst_valid = (state == ISSUE);
    halted     = (state == HALT);
    fault      = (state == FAULT);
  end

endmodule
